// File: rtl/logic_capture_axi_pkg.sv
// Shared types for the capture AXI slave front end.
// State, burst and response encodings.
package logic_capture_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic PRIO_WRITE = 1'b0;
  localparam logic PRIO_READ  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [1:0]  burst;
  } req_hdr_t;

endpackage

// File: rtl/logic_capture_axi_arb.sv
// Round-robin AW/AR grant for the capture AXI slave.
// Priority only flips when both channels contend.
module logic_capture_axi_arb
  import logic_capture_axi_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic idle_i,
  input  logic aw_valid_i,
  input  logic ar_valid_i,
  output logic aw_grant_o,
  output logic ar_grant_o
);

  logic prio_q;

  // Grant the favoured side on contention, any lone requester otherwise
  always_comb begin
    aw_grant_o = rst_ni && idle_i &&
                 (!ar_valid_i || prio_q == PRIO_WRITE);
    ar_grant_o = rst_ni && idle_i &&
                 (!aw_valid_i || prio_q == PRIO_READ);
  end

  // Hand priority to the loser after each contended grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= PRIO_WRITE;
    end else if (idle_i && aw_valid_i && ar_valid_i) begin
      prio_q <= ~prio_q;
    end
  end

endmodule

// File: rtl/logic_capture_axi_to_mem.sv
// AXI4 slave to single request port converter.
// One request per write beat, one per read burst.
module logic_capture_axi_to_mem
  import logic_capture_axi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [31:0] axi_awaddr_i,
  input  logic [3:0]  axi_awid_i,
  input  logic [7:0]  axi_awlen_i,
  input  logic [1:0]  axi_awburst_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wlast_i,
  output logic        axi_bvalid_o,
  output logic [1:0]  axi_bresp_o,
  output logic [3:0]  axi_bid_o,
  input  logic        axi_bready_i,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  input  logic [31:0] axi_araddr_i,
  input  logic [3:0]  axi_arid_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [1:0]  axi_arburst_i,
  output logic        axi_rvalid_o,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [3:0]  axi_rid_o,
  output logic        axi_rlast_o,
  input  logic        axi_rready_i,
  output logic        outport_valid_o,
  output logic        outport_write_o,
  output logic [31:0] outport_addr_o,
  output logic [3:0]  outport_id_o,
  output logic [7:0]  outport_len_o,
  output logic [1:0]  outport_burst_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  input  logic        outport_accept_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  output logic        outport_bready_o,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_rready_o
);

  state_e   state_q;
  req_hdr_t hdr_q;
  logic [7:0] cnt_q;
  logic     aw_grant;
  logic     ar_grant;
  logic     aw_hs;
  logic     ar_hs;
  logic     beat;
  logic     in_wr;
  logic     unused_wlast;

  // Bursts end on the beat count, so wlast is not needed
  assign unused_wlast = axi_wlast_i;

  logic_capture_axi_arb u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .idle_i     (state_q == ST_IDLE),
    .aw_valid_i (axi_awvalid_i),
    .ar_valid_i (axi_arvalid_i),
    .aw_grant_o (aw_grant),
    .ar_grant_o (ar_grant)
  );

  assign in_wr = (state_q == ST_WRITE);
  assign aw_hs = axi_awvalid_i && aw_grant;
  assign ar_hs = axi_arvalid_i && ar_grant;
  assign beat  = in_wr && axi_wvalid_i && outport_accept_i;

  // Sequence: latch header, emit beats or the read, return to idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (aw_hs) begin
            hdr_q   <= '{axi_awaddr_i, axi_awid_i,
                         axi_awlen_i, axi_awburst_i};
            cnt_q   <= axi_awlen_i;
            state_q <= ST_WRITE;
          end else if (ar_hs) begin
            hdr_q   <= '{axi_araddr_i, axi_arid_i,
                         axi_arlen_i, axi_arburst_i};
            state_q <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (beat) begin
            if (cnt_q == 8'd0) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        ST_READ: begin
          if (outport_accept_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request port fields and AXI readies
  always_comb begin
    axi_awready_o   = aw_grant;
    axi_arready_o   = ar_grant;
    axi_wready_o    = in_wr && outport_accept_i;
    outport_valid_o = (in_wr && axi_wvalid_i) ||
                      (state_q == ST_READ);
    outport_write_o = in_wr;
    outport_addr_o  = hdr_q.addr;
    outport_id_o    = hdr_q.id;
    outport_len_o   = hdr_q.len;
    outport_burst_o = hdr_q.burst;
    outport_wdata_o = in_wr ? axi_wdata_i : 32'd0;
    outport_wstrb_o = in_wr ? axi_wstrb_i : 4'd0;
  end

  // Responses pass straight through in both directions
  always_comb begin
    axi_bvalid_o     = outport_bvalid_i;
    axi_bresp_o      = outport_bresp_i;
    axi_bid_o        = outport_bid_i;
    outport_bready_o = axi_bready_i;
    axi_rvalid_o     = outport_rvalid_i;
    axi_rdata_o      = outport_rdata_i;
    axi_rresp_o      = outport_rresp_i;
    axi_rid_o        = outport_rid_i;
    axi_rlast_o      = outport_rlast_i;
    outport_rready_o = axi_rready_i;
  end

endmodule

// File: tb/tb_logic_capture_axi_to_mem.sv
// Scoreboard bench for logic_capture_axi_to_mem.
// Directed AW/W/AR traffic, monitor checks request port.
module tb_logic_capture_axi_to_mem;
  import logic_capture_axi_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = 0;
  logic [3:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic [1:0]  awburst = 0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wlast = 0;
  logic        bvalid, bready = 1;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = 0;
  logic [3:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic [1:0]  arburst = 0;
  logic        rvalid, rlast, rready = 1;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        o_valid, o_write;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_id, o_wstrb;
  logic [7:0]  o_len;
  logic [1:0]  o_burst;
  logic        accept = 0;
  logic        m_bvalid = 0, m_bready;
  logic [1:0]  m_bresp = 0;
  logic [3:0]  m_bid = 0;
  logic        m_rvalid = 0, m_rlast = 0, m_rready;
  logic [31:0] m_rdata = 0;
  logic [1:0]  m_rresp = 0;
  logic [3:0]  m_rid = 0;

  int n_cmp = 0;
  int n_err = 0;
  req_t exp_q[$];
  req_t mon_exp, mon_act;
  req_t cur;

  always #5 clk = ~clk;

  logic_capture_axi_to_mem dut (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_awaddr_i(awaddr), .axi_awid_i(awid),
    .axi_awlen_i(awlen), .axi_awburst_i(awburst),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb),
    .axi_wlast_i(wlast),
    .axi_bvalid_o(bvalid), .axi_bresp_o(bresp),
    .axi_bid_o(bid), .axi_bready_i(bready),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_araddr_i(araddr), .axi_arid_i(arid),
    .axi_arlen_i(arlen), .axi_arburst_i(arburst),
    .axi_rvalid_o(rvalid), .axi_rdata_o(rdata),
    .axi_rresp_o(rresp), .axi_rid_o(rid),
    .axi_rlast_o(rlast), .axi_rready_i(rready),
    .outport_valid_o(o_valid), .outport_write_o(o_write),
    .outport_addr_o(o_addr), .outport_id_o(o_id),
    .outport_len_o(o_len), .outport_burst_o(o_burst),
    .outport_wdata_o(o_wdata), .outport_wstrb_o(o_wstrb),
    .outport_accept_i(accept),
    .outport_bvalid_i(m_bvalid), .outport_bresp_i(m_bresp),
    .outport_bid_i(m_bid), .outport_bready_o(m_bready),
    .outport_rvalid_i(m_rvalid), .outport_rdata_i(m_rdata),
    .outport_rresp_i(m_rresp), .outport_rid_i(m_rid),
    .outport_rlast_i(m_rlast), .outport_rready_o(m_rready)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every cycle a request is shown it must match the
  // queue head; it is retired only when accepted
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      n_cmp++;
      mon_act = '{o_write, o_addr, o_id, o_len, o_burst,
                  o_wdata, o_wstrb};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL req_unexpected: got %h want none",
                 mon_act);
      end else begin
        mon_exp = exp_q[0];
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL req_fields: got %h want %h",
                   mon_act, mon_exp);
        end
        if (accept) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_aw(input logic [31:0] a,
                         input logic [3:0] i,
                         input logic [7:0] l,
                         input logic [1:0] b);
    int t = 0;
    awvalid = 1; awaddr = a; awid = i; awlen = l; awburst = b;
    cur = '{1'b1, a, i, l, b, 32'd0, 4'd0};
    do begin
      @(negedge clk); t++;
    end while (!awready && t < 50);
    chk("aw_handshake", {63'd0, awready}, 64'd1);
    @(posedge clk); #1;
    awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d,
                        input logic [3:0] s,
                        input logic lst,
                        input int stall);
    req_t e;
    e = cur; e.wdata = d; e.wstrb = s;
    exp_q.push_back(e);
    wvalid = 1; wdata = d; wstrb = s; wlast = lst;
    accept = 0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("wready_stall", {63'd0, wready}, 64'd0);
      @(posedge clk); #1;
    end
    accept = 1;
    @(negedge clk);
    chk("wready_acc", {63'd0, wready}, 64'd1);
    @(posedge clk); #1;
    wvalid = 0; wlast = 0; accept = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_awready", {63'd0, awready}, 64'd0);
    chk("rst_arready", {63'd0, arready}, 64'd0);
    chk("rst_req", {o_valid, o_write, o_addr}, 64'd0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;

    // Single write, accept tied high
    send_aw(32'h1000, 4'h1, 8'd0, BURST_INCR);
    send_w(32'hDEADBEEF, 4'hF, 1'b1, 0);
    @(negedge clk);
    chk("idle_awready", {63'd0, awready}, 64'd1);
    chk("idle_valid", {63'd0, o_valid}, 64'd0);
    @(posedge clk); #1;

    // INCR write of 4 beats, accept toggling
    send_aw(32'h3000, 4'h2, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++)
      send_w(32'h11110000 + i, 4'h3 << i[1:0],
             i == 3, i % 2);
    @(negedge clk);
    chk("wr4_done", {63'd0, o_valid}, 64'd0);
    @(posedge clk); #1;

    // Read arlen=7, accept delayed 3 cycles
    arvalid = 1; araddr = 32'h2000; arid = 4'h3;
    arlen = 8'd7; arburst = BURST_INCR;
    exp_q.push_back('{1'b0, 32'h2000, 4'h3, 8'd7,
                      BURST_INCR, 32'd0, 4'd0});
    @(negedge clk);
    chk("ar_ready", {63'd0, arready}, 64'd1);
    @(posedge clk); #1; arvalid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rd_held", {62'd0, o_valid, o_write}, 64'd2);
      @(posedge clk); #1;
    end
    accept = 1;
    @(posedge clk); #1; accept = 0;
    @(negedge clk);
    chk("rd_dropped", {63'd0, o_valid}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      m_rvalid = 1; m_rdata = 32'hA5A50000 + i;
      m_rid = 4'h3; m_rresp = RESP_OKAY; m_rlast = (i == 7);
      #1;
      chk("r_pass", {rvalid, rlast, rresp, rid, rdata},
          {1'b1, i == 7, RESP_OKAY, 4'h3, 32'hA5A50000 + i});
      @(posedge clk); #1;
    end
    m_rvalid = 0; m_rlast = 0;

    // Contention: write first, then read
    awvalid = 1; awaddr = 32'h6000; awid = 4'h6;
    awlen = 8'd0; awburst = BURST_FIXED;
    arvalid = 1; araddr = 32'h7000; arid = 4'h7;
    arlen = 8'd2; arburst = BURST_WRAP;
    cur = '{1'b1, 32'h6000, 4'h6, 8'd0, BURST_FIXED,
            32'd0, 4'd0};
    @(negedge clk);
    chk("arb1", {62'd0, awready, arready}, 64'd2);
    @(posedge clk); #1; awvalid = 0; arvalid = 0;
    @(negedge clk);
    chk("arb_busy", {62'd0, awready, arready}, 64'd0);
    @(posedge clk); #1;
    send_w(32'hCAFEF00D, 4'h5, 1'b1, 0);
    awvalid = 1; arvalid = 1;
    exp_q.push_back('{1'b0, 32'h7000, 4'h7, 8'd2,
                      BURST_WRAP, 32'd0, 4'd0});
    @(negedge clk);
    chk("arb2", {62'd0, awready, arready}, 64'd1);
    @(posedge clk); #1; awvalid = 0; arvalid = 0;
    accept = 1;
    @(posedge clk); #1; accept = 0;

    // Reset in the middle of an awlen=5 burst
    send_aw(32'h4000, 4'h4, 8'd5, BURST_INCR);
    send_w(32'h40000000, 4'hF, 1'b0, 0);
    send_w(32'h40000001, 4'hF, 1'b0, 0);
    wvalid = 1; wdata = 32'h40000002; wstrb = 4'hF;
    accept = 1;
    #1; rst_n = 0; #1;
    chk("mid_rst_req", {o_valid, o_write, o_addr},
        64'd0);
    chk("mid_rst_f", {o_len, o_id, o_wdata, o_wstrb}, 64'd0);
    chk("mid_rst_wr", {62'd0, wready, awready}, 64'd0);
    @(posedge clk); #1; wvalid = 0; accept = 0;
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    send_aw(32'h5000, 4'h8, 8'd1, BURST_INCR);
    send_w(32'h50000000, 4'h1, 1'b0, 1);
    send_w(32'h50000001, 4'h2, 1'b1, 0);
    @(negedge clk);
    chk("post_rst_idle", {63'd0, awready}, 64'd1);

    // B backpressure pass-through
    bready = 0; m_bvalid = 1; m_bid = 4'h5;
    m_bresp = RESP_SLVERR;
    #1;
    chk("b_pass", {m_bready, bvalid, bresp, bid},
        {1'b0, 1'b1, RESP_SLVERR, 4'h5});
    bready = 1; #1;
    chk("b_ready", {63'd0, m_bready}, 64'd1);
    rready = 0; #1;
    chk("r_ready", {63'd0, m_rready}, 64'd0);

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
